serial_alu: RTL and testbench
=============================

// Module: serial_alu
// PURPOSE
//   Multi-cycle digit-serial adder. It is the responder end of the proc<->ALU
//   in_valid/out_valid handshake and computes out = a_in + b_in mod 2^WIDTH.
//   Subtraction needs no extra logic here, because proc pre-negates b_in.
//   The adder handles DIGIT bits per cycle, which trades latency for adder width.
// PARAMETERS
//   WIDTH  32  operand/result width in bits
//   DIGIT  8   bits added per cycle; WIDTH % DIGIT == 0; N = WIDTH/DIGIT
// PORTS
//   clk        in   1      single clock; all state changes on posedge clk
//   rst        in   1      synchronous, active-high reset
//   a_in       in   WIDTH  operand A; sampled only on accept
//   b_in       in   WIDTH  operand B; sampled only on accept
//   in_valid   in   1      request; accepted only when state==IDLE
//   out        out  WIDTH  result; holds last value until next completion
//   out_valid  out  1      single-cycle pulse: out/cout valid this cycle
//   cout       out  1      carry out of bit WIDTH-1; qualified by out_valid
//   busy       out  1      high in RUN and DONE
// BEHAVIOUR
//   Reset (rst=1 at edge): state=IDLE, out=0, out_valid=0, cout=0, busy=0, count=0.
//     rst has priority over in_valid at the same edge.
//     rst mid-RUN aborts the operation: no out_valid ever follows for it.
//   FSM:
//     IDLE -> RUN on in_valid. At that edge it latches a_in/b_in into shift
//       regs, sets carry=0 and count=0.
//     RUN: each edge adds the low DIGIT bits of both shift regs plus carry.
//       The sum digit shifts into the top of the result reg, carry updates,
//       count++. After the edge where count==N-1: state goes to DONE,
//       out<=result, cout<=carry.
//     DONE: out_valid=1 for exactly one cycle; the next edge returns to IDLE.
//   Latency: accept edge ends cycle T; RUN spans cycles T+1..T+N; out_valid
//     is high in cycle T+N+1 only. Example: DIGIT=8 gives N=4, so out_valid
//     is in T+5. DIGIT=WIDTH gives out_valid in T+2.
//   out_valid is registered (state==DONE); it never depends combinationally
//     on in_valid.
//   in_valid during RUN or DONE is ignored and dropped, not queued. proc's
//     next request arrives in the cycle after the out_valid pulse, when the
//     FSM is already IDLE.
//   Changes to a_in/b_in after accept have no effect on the result.
//   Arithmetic: unsigned modulo 2^WIDTH; overflow only shows in cout; no
//     saturation.
//   count width is clog2(N), minimum 1. The last-digit compare is count==N-1,
//     so there is no wrap-around of count.
//   No X on out/out_valid/cout at any time after the first reset edge.
// STRUCTURE
//   defs.v (shared): `ALU_ST_IDLE/`ALU_ST_RUN/`ALU_ST_DONE 2-bit state
//     encodings and `ALU_WIDTH default 32.
//   Sub-module digit_adder (combinational, parameter DIGIT) takes a, b, cin
//     and produces sum and cout. It is instantiated once; the FSM, shift regs
//     and counter live in serial_alu.
// TESTING (DIGIT=8 unless stated; T = accept cycle)
//   5 + 7 -> out=0x0000000C, cout=0, out_valid high in T+5 only.
//   0xFFFFFFFF + 0x00000001 -> out=0, cout=1; carry ripples across all 4 digits.
//   Subtract: 10 + 0xFFFFFFFD -> out=7, cout=1.
//   0x000000FF + 0x00000001 -> out=0x100, which checks carry across the
//     digit-0/1 boundary.
//   Second in_valid in T+2 with 1+1, while the first request is 5+7 ->
//     ignored; exactly one out_valid, out=12.
//   a_in/b_in changed in T+1 -> result still comes from the operands latched at T.
//   rst in T+3 -> next cycle busy=0, out=0, out_valid=0. No pulse appears in
//     T+5. A new request is then accepted normally.
//   Back-to-back: in_valid in the cycle after out_valid -> accepted. With
//     DIGIT=32 this gives out_valid exactly every 3 cycles.

Source files
------------

// File: rtl/serial_alu_pkg.sv
// Shared types and constants for the digit-serial adder.
package serial_alu_pkg;

  localparam int unsigned AluWidth = 32;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } alu_state_e;

  // Digit counter width; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_alu_if.sv
// Request/response bundle between proc (master) and the serial adder (slave).
interface serial_alu_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             in_valid;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             cout;
  logic             busy;

  modport master (
    output a_in, b_in, in_valid,
    input  out, out_valid, cout, busy
  );

  modport slave (
    input  a_in, b_in, in_valid,
    output out, out_valid, cout, busy
  );
endinterface

// File: rtl/serial_alu_digit_adder.sv
// Combinational DIGIT-bit adder with carry in/out; one digit per cycle in serial_alu.
module serial_alu_digit_adder #(
  parameter int unsigned DIGIT = 8
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};

endmodule

// File: rtl/serial_alu.sv
// Digit-serial adder: out = a_in + b_in mod 2^WIDTH, DIGIT bits per cycle,
// responder end of the in_valid/out_valid handshake.
module serial_alu
  import serial_alu_pkg::*;
#(
  parameter int unsigned WIDTH = AluWidth,
  parameter int unsigned DIGIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  serial_alu_if.slave bus
);

  localparam int unsigned N    = WIDTH / DIGIT;
  localparam int unsigned CntW = cnt_width(N);
  localparam logic [CntW-1:0] LastCount = CntW'(N - 1);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CntW-1:0]  count_q, count_d;

  logic [DIGIT-1:0] sum_digit;
  logic             digit_cout;
  logic [WIDTH-1:0] res_shifted;

  serial_alu_digit_adder #(
    .DIGIT (DIGIT)
  ) u_digit_adder (
    .a    (a_q[DIGIT-1:0]),
    .b    (b_q[DIGIT-1:0]),
    .cin  (carry_q),
    .sum  (sum_digit),
    .cout (digit_cout)
  );

  // New digit enters at the top; after N digits the LSB digit sits at the bottom.
  assign res_shifted = (res_q >> DIGIT) | (WIDTH'(sum_digit) << (WIDTH - DIGIT));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    out_d   = out_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    count_d = count_q;
    case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          state_d = StRun;
          a_d     = bus.a_in;
          b_d     = bus.b_in;
          carry_d = 1'b0;
          count_d = '0;
        end
      end
      StRun: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        res_d   = res_shifted;
        carry_d = digit_cout;
        if (count_q == LastCount) begin
          state_d = StDone;
          out_d   = res_shifted;
          cout_d  = digit_cout;
        end else begin
          count_d = count_q + CntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      out_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      out_q   <= out_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      count_q <= count_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.cout      = cout_q;
  assign bus.out_valid = (state_q == StDone);
  assign bus.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_serial_alu.sv
// Randomized and directed bench for serial_alu against a plain a+b reference.
module tb_serial_alu;

  localparam int unsigned W = 32;
  localparam int unsigned D = 8;
  localparam int unsigned N = W / D;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_alu_if #(.WIDTH(W)) bus8 ();
  serial_alu_if #(.WIDTH(W)) bus32 ();

  serial_alu #(.WIDTH(W), .DIGIT(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  serial_alu #(.WIDTH(W), .DIGIT(W)) dut32 (
    .clk (clk),
    .rst (rst),
    .bus (bus32)
  );

  int vectors    = 0;
  int miscompares = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_val);
    vectors++;
    if (obs !== exp_val) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp_val);
    end
  endtask

  // mode 0: plain; 1: extra 1+1 request in T+2; 2: operands scrambled in T+1
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int mode,
                        input string tag);
    logic [32:0] exp_sum;
    int          pulses;
    int          pulse_k;
    logic [31:0] got_out;
    logic        got_cout;
    exp_sum  = {1'b0, a} + {1'b0, b};
    pulses   = 0;
    pulse_k  = 0;
    got_out  = '0;
    got_cout = 1'b0;
    @(negedge clk);
    bus8.a_in     = a;
    bus8.b_in     = b;
    bus8.in_valid = 1'b1;
    for (int k = 1; k <= int'(N) + 3; k++) begin
      @(negedge clk);
      bus8.in_valid = 1'b0;
      if (bus8.out_valid === 1'b1) begin
        pulses++;
        pulse_k  = k;
        got_out  = bus8.out;
        got_cout = bus8.cout;
      end
      if (k == 1) begin
        check_eq({tag, "/busy"}, 64'(bus8.busy), 64'(1));
        if (mode == 2) begin
          bus8.a_in = $urandom;
          bus8.b_in = $urandom;
        end
      end
      if (k == 2 && mode == 1) begin
        bus8.in_valid = 1'b1;
        bus8.a_in     = 32'd1;
        bus8.b_in     = 32'd1;
      end
    end
    check_eq({tag, "/pulses"}, 64'(pulses), 64'(1));
    check_eq({tag, "/latency"}, 64'(pulse_k), 64'(N + 1));
    check_eq({tag, "/out"}, 64'(got_out), 64'(exp_sum[31:0]));
    check_eq({tag, "/cout"}, 64'(got_cout), 64'(exp_sum[32]));
    check_eq({tag, "/out_hold"}, 64'(bus8.out), 64'(exp_sum[31:0]));
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 4))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h0000_0000;
      2:       return 32'h0000_00FF << (8 * $urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int          pulses;
    int          k;
    logic        found;
    logic [32:0] exp32;
    logic [31:0] ra, rb;

    rst            = 1'b1;
    bus8.a_in      = 32'd5;
    bus8.b_in      = 32'd7;
    bus8.in_valid  = 1'b1;
    bus32.a_in     = '0;
    bus32.b_in     = '0;
    bus32.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    // in_valid was high alongside rst: reset must win
    check_eq("rst/out", 64'(bus8.out), 64'(0));
    check_eq("rst/out_valid", 64'(bus8.out_valid), 64'(0));
    check_eq("rst/cout", 64'(bus8.cout), 64'(0));
    check_eq("rst/busy", 64'(bus8.busy), 64'(0));
    check_eq("rst32/out_valid", 64'(bus32.out_valid), 64'(0));
    check_eq("rst32/busy", 64'(bus32.busy), 64'(0));
    rst           = 1'b0;
    bus8.in_valid = 1'b0;

    run_op(32'd5, 32'd7, 0, "5+7");
    run_op(32'hFFFF_FFFF, 32'd1, 0, "ripple");
    run_op(32'd10, 32'hFFFF_FFFD, 0, "sub");
    run_op(32'h0000_00FF, 32'd1, 0, "digit_carry");
    run_op(32'd5, 32'd7, 1, "drop");
    run_op(32'h1234_5678, 32'h0F0F_0F0F, 2, "latch");

    // Abort mid-run: no pulse may follow for the aborted request
    pulses = 0;
    @(negedge clk);
    bus8.a_in     = 32'd5;
    bus8.b_in     = 32'd7;
    bus8.in_valid = 1'b1;
    for (int j = 1; j <= 7; j++) begin
      @(negedge clk);
      bus8.in_valid = 1'b0;
      if (j > 3 && bus8.out_valid === 1'b1) pulses++;
      if (j == 3) rst = 1'b1;
      if (j == 4) begin
        check_eq("abort/busy", 64'(bus8.busy), 64'(0));
        check_eq("abort/out", 64'(bus8.out), 64'(0));
        check_eq("abort/out_valid", 64'(bus8.out_valid), 64'(0));
        rst = 1'b0;
      end
    end
    check_eq("abort/pulses", 64'(pulses), 64'(0));
    run_op(32'd3, 32'd4, 0, "after_rst");

    for (int i = 0; i < 20; i++) begin
      run_op(pick_operand(), pick_operand(), int'($urandom_range(0, 2)), $sformatf("rand%0d", i));
    end

    // DIGIT=WIDTH instance: proc issues each request the cycle after the pulse
    @(negedge clk);
    ra = $urandom;
    rb = $urandom;
    bus32.a_in     = ra;
    bus32.b_in     = rb;
    bus32.in_valid = 1'b1;
    exp32 = {1'b0, ra} + {1'b0, rb};
    for (int j = 0; j < 6; j++) begin
      found = 1'b0;
      k     = 0;
      while (!found && k < 6) begin
        @(negedge clk);
        k++;
        bus32.in_valid = 1'b0;
        if (bus32.out_valid === 1'b1) found = 1'b1;
      end
      check_eq($sformatf("b2b%0d/seen", j), 64'(found), 64'(1));
      check_eq($sformatf("b2b%0d/period", j), 64'(k + 1), 64'(3));
      check_eq($sformatf("b2b%0d/out", j), 64'(bus32.out), 64'(exp32[31:0]));
      check_eq($sformatf("b2b%0d/cout", j), 64'(bus32.cout), 64'(exp32[32]));
      @(negedge clk);
      ra = pick_operand();
      rb = pick_operand();
      bus32.a_in     = ra;
      bus32.b_in     = rb;
      bus32.in_valid = (j < 5);
      exp32 = {1'b0, ra} + {1'b0, rb};
    end
    @(negedge clk);
    bus32.in_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
